// File: rtl/phy_tx_lane_sched_if.sv
// Bundle between the four lane sources and the TX byte-slot scheduler.
// The master side is the lane sources; the slave side is the scheduler.
interface phy_tx_lane_sched_if;
  logic [3:0] lane_en;
  logic [3:0] req;
  logic [7:0] in0;
  logic [7:0] in1;
  logic [7:0] in2;
  logic [7:0] in3;
  logic [3:0] gnt;
  logic [7:0] data_out;
  logic       valid_out;
  logic       IDLE;
  logic [1:0] lane_sel;
  logic       sync_done;

  modport master (
    output lane_en, req, in0, in1, in2, in3,
    input  gnt, data_out, valid_out, IDLE, lane_sel, sync_done
  );

  modport slave (
    input  lane_en, req, in0, in1, in2, in3,
    output gnt, data_out, valid_out, IDLE, lane_sel, sync_done
  );
endinterface

// File: rtl/phy_tx_lane_sched.sv
// Round-robin byte scheduler sharing one serial TX byte slot among four lanes.
// Sends COMMA training slots after reset, then one granted byte (or IDLE_CHAR) per slot.
module phy_tx_lane_sched #(
  parameter int         SLOT_CYCLES = 8,
  parameter int         SYNC_SLOTS  = 4,
  parameter logic [7:0] COMMA       = 8'hBC,
  parameter logic [7:0] IDLE_CHAR   = 8'h7C
) (
  input logic               clk_32f,
  input logic               rst,
  phy_tx_lane_sched_if.slave bus
);

  localparam int SCW = $clog2(SLOT_CYCLES);
  localparam int YCW = (SYNC_SLOTS > 1) ? $clog2(SYNC_SLOTS) : 1;
  localparam logic [SCW-1:0] SLOT_LAST = SCW'(SLOT_CYCLES - 1);
  localparam logic [YCW-1:0] SYNC_LAST = YCW'(SYNC_SLOTS - 1);

  typedef enum logic {SYNC, ACTIVE} state_t;

  state_t         state_reg;
  logic [SCW-1:0] slot_cnt_reg;
  logic [YCW-1:0] sync_cnt_reg;
  logic [1:0]     rr_ptr_reg;
  logic [3:0]     gnt_reg;
  logic [7:0]     data_out_reg;
  logic           valid_out_reg;
  logic           idle_reg;
  logic [1:0]     lane_sel_reg;
  logic           sync_done_reg;

  logic [7:0] lane_data [4];
  logic [3:0] elig;
  logic [1:0] cand_idx [4];
  logic [1:0] win;
  logic       found;
  logic       boundary;
  logic       do_arb;

  assign lane_data[0] = bus.in0;
  assign lane_data[1] = bus.in1;
  assign lane_data[2] = bus.in2;
  assign lane_data[3] = bus.in3;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign elig[gi]     = bus.req[gi] & bus.lane_en[gi];
      assign cand_idx[gi] = rr_ptr_reg + 2'(gi);
    end
  endgenerate

  // Scan from the farthest candidate down so the one nearest rr_ptr wins.
  always_comb begin
    found = 1'b0;
    win   = rr_ptr_reg;
    for (int k = 3; k >= 0; k--) begin
      if (elig[cand_idx[k]]) begin
        found = 1'b1;
        win   = cand_idx[k];
      end
    end
  end

  assign boundary = (slot_cnt_reg == SLOT_LAST);
  assign do_arb   = boundary && ((state_reg == ACTIVE) || (sync_cnt_reg == SYNC_LAST));

  always_ff @(posedge clk_32f or negedge rst) begin
    if (!rst) begin
      state_reg     <= SYNC;
      slot_cnt_reg  <= '0;
      sync_cnt_reg  <= '0;
      rr_ptr_reg    <= 2'd0;
      gnt_reg       <= 4'b0000;
      data_out_reg  <= COMMA;
      valid_out_reg <= 1'b0;
      idle_reg      <= 1'b1;
      lane_sel_reg  <= 2'd0;
      sync_done_reg <= 1'b0;
    end else begin
      slot_cnt_reg <= boundary ? '0 : slot_cnt_reg + SCW'(1);
      gnt_reg      <= 4'b0000;

      if (boundary && state_reg == SYNC) begin
        if (sync_cnt_reg == SYNC_LAST) begin
          state_reg     <= ACTIVE;
          sync_done_reg <= 1'b1;
        end else begin
          sync_cnt_reg <= sync_cnt_reg + YCW'(1);
          data_out_reg <= COMMA;
        end
      end

      if (do_arb) begin
        if (found) begin
          data_out_reg  <= lane_data[win];
          valid_out_reg <= 1'b1;
          idle_reg      <= 1'b0;
          lane_sel_reg  <= win;
          gnt_reg       <= 4'b0001 << win;
          rr_ptr_reg    <= win + 2'd1;
        end else begin
          data_out_reg  <= IDLE_CHAR;
          valid_out_reg <= 1'b0;
          idle_reg      <= 1'b1;
        end
      end
    end
  end

  assign bus.gnt       = gnt_reg;
  assign bus.data_out  = data_out_reg;
  assign bus.valid_out = valid_out_reg;
  assign bus.IDLE      = idle_reg;
  assign bus.lane_sel  = lane_sel_reg;
  assign bus.sync_done = sync_done_reg;

endmodule

// File: tb/tb_phy_tx_lane_sched.sv
// Scoreboard bench for phy_tx_lane_sched: the driver pushes hand-computed slot
// expectations, a monitor pops and compares one entry per byte slot.
module tb_phy_tx_lane_sched;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   tb_cnt = 0;
  logic [7:0] last_data = 8'hBC;

  typedef struct {
    logic [7:0] data;
    logic       valid;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       sync;
  } exp_t;

  exp_t exp_q[$];

  phy_tx_lane_sched_if bus();

  phy_tx_lane_sched dut (
    .clk_32f (clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Bench-side slot position, restarted by reset just like the scheduler's.
  always @(posedge clk or negedge rst) begin
    if (!rst) tb_cnt <= 0;
    else      tb_cnt <= (tb_cnt == 7) ? 0 : tb_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic v, input logic [1:0] sel,
                      input logic [3:0] g, input logic s);
    exp_t e;
    e.data = d; e.valid = v; e.sel = sel; e.gnt = g; e.sync = s;
    exp_q.push_back(e);
  endtask

  // Drive inputs mid-slot so they are sampled at the next boundary.
  task automatic apply(input logic [3:0] en, input logic [3:0] rq, input logic [7:0] d,
                       input logic v, input logic [1:0] sel, input logic [3:0] g,
                       input logic s);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rst && tb_cnt == 3) && n < 64);
    if (n >= 64) begin
      total++; bad++;
      $display("FAIL apply_timeout: got no mid-slot point want one within 64 cycles");
    end
    bus.lane_en = en;
    bus.req     = rq;
    push(d, v, sel, g, s);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    push(8'hBC, 1'b0, 2'd0, 4'b0000, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_data"},  bus.data_out,  8'hBC);
    chk({tag, "_valid"}, bus.valid_out, 1'b0);
    chk({tag, "_idle"},  bus.IDLE,      1'b1);
    chk({tag, "_gnt"},   bus.gnt,       4'b0000);
    chk({tag, "_sel"},   bus.lane_sel,  2'd0);
    chk({tag, "_sync"},  bus.sync_done, 1'b0);
  endtask

  // Monitor: one expectation per slot, plus gnt-width and mid-slot hold checks.
  initial begin
    exp_t e;
    logic exp_idle;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (tb_cnt == 0) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL slot_underflow: got slot data=%0h want no slot", bus.data_out);
          end else begin
            e = exp_q.pop_front();
            last_data = e.data;
            exp_idle  = !e.valid;
            chk("data",      bus.data_out,  e.data);
            chk("valid",     bus.valid_out, e.valid);
            chk("idle",      bus.IDLE,      exp_idle);
            chk("lane_sel",  bus.lane_sel,  e.sel);
            chk("gnt",       bus.gnt,       e.gnt);
            chk("sync_done", bus.sync_done, e.sync);
            $display("slot t=%0t data=%0h valid=%0b idle=%0b sel=%0d gnt=%b sync=%0b",
                     $time, bus.data_out, bus.valid_out, bus.IDLE, bus.lane_sel,
                     bus.gnt, bus.sync_done);
          end
        end else if (tb_cnt == 1) begin
          chk("gnt_one_cycle", bus.gnt, 4'b0000);
        end else if (tb_cnt == 5) begin
          chk("data_hold", bus.data_out, last_data);
        end
      end
    end
  end

  initial begin
    int n;
    bus.lane_en = 4'b1111;
    bus.req     = 4'b0000;
    bus.in0 = 8'h11; bus.in1 = 8'h22; bus.in2 = 8'h33; bus.in3 = 8'h44;

    // T1: reset and training; req during training must be ignored
    repeat (3) @(posedge clk);
    #1 chk_reset_vals("in_reset");
    release_reset();
    for (int s = 1; s < 4; s++) apply(4'b1111, 4'b1111, 8'hBC, 1'b0, 2'd0, 4'b0000, 1'b0);
    apply(4'b1111, 4'b0000, 8'h7C, 1'b0, 2'd0, 4'b0000, 1'b1);

    // T2: all lanes requesting rotate 0,1,2,3,0
    apply(4'b1111, 4'b1111, 8'h11, 1'b1, 2'd0, 4'b0001, 1'b1);
    apply(4'b1111, 4'b1111, 8'h22, 1'b1, 2'd1, 4'b0010, 1'b1);
    apply(4'b1111, 4'b1111, 8'h33, 1'b1, 2'd2, 4'b0100, 1'b1);
    apply(4'b1111, 4'b1111, 8'h44, 1'b1, 2'd3, 4'b1000, 1'b1);
    apply(4'b1111, 4'b1111, 8'h11, 1'b1, 2'd0, 4'b0001, 1'b1);

    // T3: lanes 1 and 3 alternate (rr_ptr=1 here)
    apply(4'b1111, 4'b1010, 8'h22, 1'b1, 2'd1, 4'b0010, 1'b1);
    apply(4'b1111, 4'b1010, 8'h44, 1'b1, 2'd3, 4'b1000, 1'b1);
    apply(4'b1111, 4'b1010, 8'h22, 1'b1, 2'd1, 4'b0010, 1'b1);
    apply(4'b1111, 4'b1010, 8'h44, 1'b1, 2'd3, 4'b1000, 1'b1);

    // T4: only requester is disabled -> filler, lane_sel holds 3
    apply(4'b1110, 4'b0001, 8'h7C, 1'b0, 2'd3, 4'b0000, 1'b1);
    apply(4'b1110, 4'b0001, 8'h7C, 1'b0, 2'd3, 4'b0000, 1'b1);

    // T5: single lane2 request, drop, then 1101 from rr_ptr=3
    bus.in2 = 8'h5A;
    apply(4'b1111, 4'b0100, 8'h5A, 1'b1, 2'd2, 4'b0100, 1'b1);
    apply(4'b1111, 4'b0000, 8'h7C, 1'b0, 2'd2, 4'b0000, 1'b1);
    apply(4'b1111, 4'b1101, 8'h44, 1'b1, 2'd3, 4'b1000, 1'b1);
    apply(4'b1111, 4'b1101, 8'h11, 1'b1, 2'd0, 4'b0001, 1'b1);
    apply(4'b1111, 4'b1101, 8'h5A, 1'b1, 2'd2, 4'b0100, 1'b1);

    // T6: async reset at slot_cnt=3 mid-ACTIVE, then training restarts
    drain();
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (tb_cnt != 3 && n < 16);
    rst = 1'b0;
    #1 chk_reset_vals("mid_active_reset");
    repeat (2) @(posedge clk);
    release_reset();
    for (int s = 1; s < 4; s++) apply(4'b1111, 4'b1111, 8'hBC, 1'b0, 2'd0, 4'b0000, 1'b0);
    apply(4'b1111, 4'b1111, 8'h11, 1'b1, 2'd0, 4'b0001, 1'b1);
    apply(4'b1111, 4'b1111, 8'h22, 1'b1, 2'd1, 4'b0010, 1'b1);
    drain();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
